wb_regfile: RTL and testbench

Writeback-stage register file: the consumer end of the MEM/WB pipeline register. It receives the registered writeback result (`wb_data`, `wb_rd`) and commits it to a 32-entry architectural register array. It serves two combinational read ports to the decode stage, with same-cycle write-through bypass so decode never reads a stale value for an in-flight writeback. A committed-write counter and a last-write record support debug and the hazard logic.

---
 rtl/wb_regfile.sv | 78 +++++++
 tb/tb_wb_regfile.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback-stage register file: commits MEM/WB results into 2^ADDR_W registers
// and serves two combinational read ports with same-cycle write-through bypass.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [ADDR_W-1:0] last_rd,
    output logic              last_valid,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              commit;
    logic              cnt_full;

    // wb_rd == 0 is a pipeline bubble, so index 0 is never written
    assign commit   = (wb_rd != '0);
    assign cnt_full = (wr_count == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_rd    <= '0;
            last_valid <= 1'b0;
            wr_count   <= '0;
        end else if (commit) begin
            last_rd    <= wb_rd;
            last_valid <= 1'b1;
            if (!cnt_full) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    // Bypass beats the array so decode never sees a stale in-flight value
    always_comb begin
        rs_data = '0;
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (rs_addr == wb_rd) begin
            rs_data = wb_data;
        end else begin
            rs_data = regs[rs_addr];
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (rt_addr == wb_rd) begin
            rt_data = wb_data;
        end else begin
            rt_data = regs[rt_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared against an array-based architectural model.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  last_rd;
    logic        last_valid;
    logic [15:0] wr_count;

    logic [31:0] wb_data2;
    logic [4:0]  wb_rd2;
    logic [4:0]  rs_addr2;
    logic [4:0]  rt_addr2;
    logic [31:0] rs_data2;
    logic [31:0] rt_data2;
    logic [4:0]  last_rd2;
    logic        last_valid2;
    logic [3:0]  wr_count2;

    int checks;
    int failures;

    logic [31:0] model [32];
    logic [4:0]  m_last_rd;
    logic        m_last_valid;
    int          m_count;
    int          m_count2;

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .wb_data(wb_data), .wb_rd(wb_rd),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .last_rd(last_rd), .last_valid(last_valid),
        .wr_count(wr_count)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .wb_data(wb_data2), .wb_rd(wb_rd2),
        .rs_addr(rs_addr2), .rt_addr(rt_addr2),
        .rs_data(rs_data2), .rt_data(rt_data2),
        .last_rd(last_rd2), .last_valid(last_valid2),
        .wr_count(wr_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (a == wb_rd) return wb_data;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        m_last_rd    = 5'd0;
        m_last_valid = 1'b0;
        m_count      = 0;
        m_count2     = 0;
    endtask

    // One rising edge; the model commits exactly what the DUT sees there
    task automatic step();
        @(posedge clk);
        if (!rst && wb_rd != 5'd0) begin
            model[wb_rd] = wb_data;
            m_last_rd    = wb_rd;
            m_last_valid = 1'b1;
            if (m_count < 65535) m_count++;
        end
        if (!rst && wb_rd2 != 5'd0 && m_count2 < 15) m_count2++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_model();
        wb_rd = 0; wb_data = 0; rs_addr = 5'd9; rt_addr = 5'd31;
        #3;
        checks++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_read: rs=%h rt=%h required 0", rs_data, rt_data);
        end
        checks++;
        if (wr_count !== 16'd0 || last_valid !== 1'b0 || last_rd !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: cnt=%0d lv=%b lrd=%0d required 0",
                     wr_count, last_valid, last_rd);
        end
        wb_rd = 5'd4; wb_data = 32'hCAFE0004; rs_addr = 5'd4;
        #1;
        checks++;
        if (rs_data !== 32'hCAFE0004) begin
            failures++;
            $display("FAIL reset_bypass: rs=%h required cafe0004", rs_data);
        end
        step();
        checks++;
        if (wr_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_no_commit: cnt=%0d required 0", wr_count);
        end
        wb_rd = 0;
        rst = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_discard: rs=%h required 0", rs_data);
        end
    endtask

    task automatic test_basic();
        wb_rd = 5'd7; wb_data = 32'h12345678; rs_addr = 5'd7; rt_addr = 5'd0;
        #1;
        checks++;
        if (rs_data !== 32'h12345678) begin
            failures++;
            $display("FAIL basic_bypass: rs=%h required 12345678", rs_data);
        end
        step();
        wb_rd = 5'd0; wb_data = 32'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rs_data !== 32'h12345678) begin
                failures++;
                $display("FAIL basic_array: cyc=%0d rs=%h required 12345678", c, rs_data);
            end
            checks++;
            if (wr_count !== 16'd1 || last_rd !== 5'd7 || last_valid !== 1'b1) begin
                failures++;
                $display("FAIL basic_track: cnt=%0d lrd=%0d lv=%b required 1/7/1",
                         wr_count, last_rd, last_valid);
            end
            step();
        end
    endtask

    task automatic test_r0();
        logic [15:0] cnt0;
        logic        lv0;
        cnt0 = wr_count; lv0 = last_valid;
        wb_rd = 5'd0; wb_data = 32'hFFFFFFFF; rs_addr = 5'd0; rt_addr = 5'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
                failures++;
                $display("FAIL r0_read: rs=%h rt=%h required 0", rs_data, rt_data);
            end
            step();
        end
        checks++;
        if (wr_count !== cnt0 || last_valid !== lv0 || wr_count !== m_count[15:0]) begin
            failures++;
            $display("FAIL r0_track: cnt=%0d lv=%b required %0d/%b", wr_count, last_valid, cnt0, lv0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [4];
        exp[0] = 32'hA; exp[1] = 32'hB; exp[2] = 32'hB; exp[3] = 32'hB;
        rs_addr = 5'd3; rt_addr = 5'd3;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin wb_rd = 5'd3; wb_data = 32'hA; end
            else if (c == 1) begin wb_rd = 5'd3; wb_data = 32'hB; end
            else begin wb_rd = 5'd0; wb_data = 32'h0; end
            #1;
            checks++;
            if (rs_data !== exp[c] || rt_data !== exp[c]) begin
                failures++;
                $display("FAIL b2b: cyc=%0d rs=%h rt=%h required %h", c, rs_data, rt_data, exp[c]);
            end
            step();
        end
    endtask

    task automatic test_dual_port();
        wb_rd = 5'd1; wb_data = 32'h11;
        step();
        wb_rd = 5'd2; wb_data = 32'h22; rs_addr = 5'd1; rt_addr = 5'd2;
        #1;
        checks++;
        if (rs_data !== 32'h11 || rt_data !== 32'h22) begin
            failures++;
            $display("FAIL dual_port: rs=%h rt=%h required 11/22", rs_data, rt_data);
        end
        step();
        wb_rd = 5'd0;
    endtask

    task automatic test_reset_mid();
        wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        wb_rd = 5'd0; rs_addr = 5'd5;
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        checks++;
        if (rs_data !== 32'd0 || wr_count !== 16'd0 || last_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: rs=%h cnt=%0d lv=%b required 0/0/0",
                     rs_data, wr_count, last_valid);
        end
        step();
        rst = 1'b0;
        wb_rd = 5'd6; wb_data = 32'h66;
        step();
        wb_rd = 5'd0; rs_addr = 5'd6;
        #1;
        checks++;
        if (rs_data !== 32'h66 || wr_count !== 16'd1 || last_rd !== 5'd6) begin
            failures++;
            $display("FAIL reset_resume: rs=%h cnt=%0d lrd=%0d required 66/1/6",
                     rs_data, wr_count, last_rd);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wb_rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data = $urandom;
            rs_addr = ($urandom_range(0, 4) == 0) ? wb_rd : 5'($urandom_range(0, 31));
            rt_addr = ($urandom_range(0, 4) == 0) ? rs_addr : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (rs_data !== exp_rd(rs_addr) || rt_data !== exp_rd(rt_addr)) begin
                failures++;
                $display("FAIL rand_read: n=%0d rs[%0d]=%h rt[%0d]=%h required %h/%h",
                         n, rs_addr, rs_data, rt_addr, rt_data,
                         exp_rd(rs_addr), exp_rd(rt_addr));
            end
            step();
            checks++;
            if (wr_count !== m_count[15:0] || last_valid !== m_last_valid ||
                last_rd !== m_last_rd) begin
                failures++;
                $display("FAIL rand_track: n=%0d cnt=%0d lv=%b lrd=%0d required %0d/%b/%0d",
                         n, wr_count, last_valid, last_rd, m_count, m_last_valid, m_last_rd);
            end
        end
        wb_rd = 5'd0;
    endtask

    task automatic test_saturation();
        int base;
        base = m_count2;
        for (int n = 0; n < 20; n++) begin
            wb_rd2   = 5'((n % 31) + 1);
            wb_data2 = $urandom;
            step();
            checks++;
            if (wr_count2 !== 4'(m_count2)) begin
                failures++;
                $display("FAIL sat_count: n=%0d cnt=%0d required %0d", n, wr_count2, m_count2);
            end
        end
        wb_rd2 = 5'd0;
        step();
        checks++;
        if (base != 0 || wr_count2 !== 4'd15) begin
            failures++;
            $display("FAIL sat_hold: cnt=%0d base=%0d required 15", wr_count2, base);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        wb_rd2 = 0; wb_data2 = 0; rs_addr2 = 0; rt_addr2 = 0;
        test_reset();
        test_basic();
        test_r0();
        test_back_to_back();
        test_dual_port();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
